// File: rtl/keypad_if.sv
// Key request channel between a requester and the keypad emulator.
// Requester drives key_code/key_valid; emulator returns key_ready/busy/done.
// key_code must stay stable while key_valid is high.
interface keypad_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       busy;
    logic       done;

    modport master (
        output key_code,
        output key_valid,
        input  key_ready,
        input  busy,
        input  done
    );

    modport slave (
        input  key_code,
        input  key_valid,
        output key_ready,
        output busy,
        output done
    );
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 row-scan keypad responder, presses one key per request; KEYPAD_BOUNCE_EN adds edge chatter.
// Latency: keyCol follows keyRow combinationally; key held for HOLD_HITS row hits, then released for GAP_CYCLES.
// Backpressure: key_ready only in IDLE; a request held during PRESS/GAP is taken on the first IDLE cycle.
module keypad_emulator #(
    parameter int HOLD_HITS     = 8,
    parameter int GAP_CYCLES    = 16,
    parameter int BOUNCE_CYCLES = 6
) (
    input  logic       clk_div,
    input  logic       rst_n,
    input  logic [3:0] keyRow,
    output logic [3:0] keyCol,
    keypad_if.slave    key_if
);
    localparam int HOLD_EFF = (HOLD_HITS < 1) ? 1 : HOLD_HITS;
    localparam int GAP_EFF  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int HIT_W_R  = $clog2(HOLD_HITS + 1);
    localparam int GAP_W_R  = $clog2(GAP_CYCLES + 1);
    localparam int HIT_W    = (HIT_W_R < 1) ? 1 : HIT_W_R;
    localparam int GAP_W    = (GAP_W_R < 1) ? 1 : GAP_W_R;
    localparam logic [HIT_W-1:0] HIT_LAST = HIT_W'(HOLD_EFF - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_EFF - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]       state;
    logic [3:0]       trow;
    logic [3:0]       tcol;
    logic [HIT_W-1:0] hit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             done_q;
    logic             row_hit;
    logic             hit_ok;
    logic             in_bnc;
    logic             toggle;

    // {row strobe, column pulled low} for each key code
    function automatic logic [7:0] key_map(input logic [3:0] k);
        logic [7:0] rc;
        case (k)
            4'h7: rc = {4'b1110, 4'b1110};
            4'h4: rc = {4'b1110, 4'b1101};
            4'h1: rc = {4'b1110, 4'b1011};
            4'h0: rc = {4'b1110, 4'b0111};
            4'h8: rc = {4'b1101, 4'b1110};
            4'h5: rc = {4'b1101, 4'b1101};
            4'h2: rc = {4'b1101, 4'b1011};
            4'hA: rc = {4'b1101, 4'b0111};
            4'h9: rc = {4'b1011, 4'b1110};
            4'h6: rc = {4'b1011, 4'b1101};
            4'h3: rc = {4'b1011, 4'b1011};
            4'hB: rc = {4'b1011, 4'b0111};
            4'hC: rc = {4'b0111, 4'b1110};
            4'hD: rc = {4'b0111, 4'b1101};
            4'hE: rc = {4'b0111, 4'b1011};
            default: rc = {4'b0111, 4'b0111};
        endcase
        return rc;
    endfunction

    assign row_hit = (keyRow == trow);
    assign hit_ok  = (state == ST_PRESS) && row_hit && !in_bnc;

`ifdef KEYPAD_BOUNCE_EN
    localparam int BNC_W_R = $clog2(BOUNCE_CYCLES + 1);
    localparam int BNC_W   = (BNC_W_R < 1) ? 1 : BNC_W_R;
    localparam logic [BNC_W-1:0] BNC_END = BNC_W'(BOUNCE_CYCLES);

    logic [BNC_W-1:0] bnc_cnt;
    logic             enter;

    // chatter window restarts on entry to PRESS and to GAP
    assign enter  = ((state == ST_IDLE) && key_if.key_valid) ||
                    (hit_ok && (hit_cnt == HIT_LAST));
    assign in_bnc = (bnc_cnt != BNC_END);

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            bnc_cnt <= '0;
            toggle  <= 1'b0;
        end else if (enter) begin
            bnc_cnt <= '0;
            toggle  <= 1'b0;
        end else begin
            toggle <= ~toggle;
            if (in_bnc) bnc_cnt <= bnc_cnt + BNC_W'(1);
        end
    end
`else
    logic unused_bnc;
    assign unused_bnc = ^BOUNCE_CYCLES;
    assign in_bnc     = 1'b0;
    assign toggle     = 1'b1;
`endif

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            trow    <= 4'hF;
            tcol    <= 4'hF;
            hit_cnt <= '0;
            gap_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (key_if.key_valid) begin
                        {trow, tcol} <= key_map(key_if.key_code);
                        hit_cnt      <= '0;
                        state        <= ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (hit_ok) begin
                        hit_cnt <= hit_cnt + HIT_W'(1);
                        if (hit_cnt == HIT_LAST) begin
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // combinational so the scanner sees the column in the same cycle it strobes the row
    always_comb begin
        keyCol = 4'hF;
        if ((state == ST_PRESS) && row_hit && (!in_bnc || toggle)) keyCol = tcol;
        if ((state == ST_GAP) && row_hit && in_bnc && toggle)      keyCol = tcol;
    end

    assign key_if.key_ready = (state == ST_IDLE);
    assign key_if.busy      = (state != ST_IDLE);
    assign key_if.done      = done_q;
endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: a behavioural press/gap model checks every cycle,
// and each done pulse is matched against the key the attached scanner decoded.
module tb_keypad_emulator;
    localparam int HOLD = 8;
    localparam int GAP  = 16;
    localparam int BNC  = 6;
`ifdef KEYPAD_BOUNCE_EN
    localparam int BNC_EFF = BNC;
`else
    localparam int BNC_EFF = 0;
`endif

    logic       clk_div = 1'b0;
    logic       rst_n;
    logic [3:0] keyRow;
    logic [3:0] keyCol;
    keypad_if   kif();

    keypad_emulator #(.HOLD_HITS(HOLD), .GAP_CYCLES(GAP), .BOUNCE_CYCLES(BNC)) dut (
        .clk_div (clk_div),
        .rst_n   (rst_n),
        .keyRow  (keyRow),
        .keyCol  (keyCol),
        .key_if  (kif)
    );

    always #5 clk_div = ~clk_div;

    int checks = 0;
    int errors = 0;

    // keypad face: index = row*4 + col, row/col = position of the low bit
    logic [3:0] layout [16] = '{4'h7, 4'h4, 4'h1, 4'h0, 4'h8, 4'h5, 4'h2, 4'hA,
                                4'h9, 4'h6, 4'h3, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    logic [3:0] exp_q [$];
    int         scan_mode = 2;
    int         scan_idx  = 0;
    logic [3:0] hold_row  = 4'hF;
    logic [3:0] scan_val  = 4'hF;
    int         low_cnt   = 0;
    int         done_seen = 0;

    // model: phase 0 idle, 1 key pressed, 2 released gap
    int         m_ph = 0;
    int         m_left = 0;
    int         m_age = 0;
    logic [3:0] m_row = 4'hF;
    logic [3:0] m_col = 4'hF;
    bit         m_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pos_of(input logic [3:0] k);
        for (int i = 0; i < 16; i++) if (layout[i] == k) return i;
        return 0;
    endfunction

    function automatic int low_bit(input logic [3:0] v);
        case (v)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // scanner: rotate (0), stuck all-high (1), random (2), hold one row (3)
    initial begin
        keyRow = 4'hF;
        forever begin
            @(posedge clk_div); #1;
            case (scan_mode)
                0: begin scan_idx = (scan_idx + 1) % 4; keyRow = ~(4'b0001 << scan_idx); end
                1: keyRow = 4'hF;
                3: keyRow = hold_row;
                default: begin
                    if ($urandom_range(0, 9) == 0) keyRow = 4'($urandom);
                    else keyRow = ~(4'b0001 << $urandom_range(0, 3));
                end
            endcase
        end
    end

    // monitor: per-cycle model comparison, scanner decode, scoreboard on done
    initial begin
        logic [3:0] exp_col;
        int r, c, p;
        bit nd;
        forever begin
            @(negedge clk_div);
            exp_col = 4'hF;
            if (!rst_n) begin
                m_ph = 0; m_done = 1'b0; low_cnt = 0;
                exp_q.delete();
            end else if (keyRow == m_row) begin
                if (m_ph == 1 && (m_age >= BNC_EFF || m_age % 2 == 1)) exp_col = m_col;
                if (m_ph == 2 && m_age < BNC_EFF && m_age % 2 == 1)    exp_col = m_col;
            end
            check("outputs{col,ready,busy,done}",
                  {keyCol, kif.key_ready, kif.busy, kif.done},
                  {exp_col, m_ph == 0, m_ph != 0, m_done});

            if (keyCol != 4'hF) begin
                r = low_bit(keyRow);
                c = low_bit(keyCol);
                if (r >= 0 && c >= 0) scan_val = layout[r*4 + c];
                low_cnt++;
            end
            if (kif.done) begin
                done_seen++;
                if (exp_q.size() == 0) check("done_without_request", 1, 0);
                else check("scanned_key", scan_val, exp_q.pop_front());
`ifndef KEYPAD_BOUNCE_EN
                check("pressed_cycles", low_cnt, HOLD);
`endif
                low_cnt = 0;
            end

            if (rst_n) begin
                nd = 1'b0;
                case (m_ph)
                    0: if (kif.key_valid) begin
                        p = pos_of(kif.key_code);
                        m_row = ~(4'b0001 << (p / 4));
                        m_col = ~(4'b0001 << (p % 4));
                        m_left = HOLD; m_ph = 1; m_age = 0;
                    end
                    1: begin
                        if (keyRow == m_row && m_age >= BNC_EFF) m_left--;
                        if (m_left == 0) begin m_ph = 2; m_left = GAP; m_age = 0; end
                        else m_age++;
                    end
                    default: begin
                        m_left--;
                        if (m_left == 0) begin m_ph = 0; nd = 1'b1; end
                        else m_age++;
                    end
                endcase
                m_done = nd;
            end
        end
    end

    task automatic send_key(input logic [3:0] k, input bit hold, input bit exp_done_at_accept);
        int n = 0;
        @(posedge clk_div); #1;
        kif.key_code  = k;
        kif.key_valid = 1'b1;
        exp_q.push_back(k);
        @(negedge clk_div);
        while (!kif.key_ready && n < 2000) begin @(negedge clk_div); n++; end
        if (n >= 2000) check("accept_timeout", 0, 1);
        if (exp_done_at_accept) check("accept_on_done", kif.done, 1);
        @(posedge clk_div); #1;
        if (!hold) kif.key_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk_div);
        while ((kif.busy || exp_q.size() != 0) && n < 3000) begin @(negedge clk_div); n++; end
        if (n >= 3000) check("idle_timeout", 0, 1);
    endtask

    initial begin
        logic [3:0] order [16];
        int j, n, d0;
        logic [3:0] t;
        rst_n = 1'b0;
        kif.key_code  = 4'h0;
        kif.key_valid = 1'b0;
        repeat (5) @(posedge clk_div);
        @(negedge clk_div); #2 rst_n = 1'b1;

        scan_mode = 0;
        send_key(4'h5, 1'b0, 1'b0);
        wait_idle();

        for (int i = 0; i < 16; i++) order[i] = 4'(i);
        for (int i = 15; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 16; i++) begin
            scan_mode = ($urandom_range(0, 2) == 0) ? 2 : 0;
            repeat ($urandom_range(0, 3)) @(posedge clk_div);
            send_key(order[i], 1'b0, 1'b0);
        end
        wait_idle();
        scan_mode = 0;

        send_key(4'h3, 1'b1, 1'b0);
        send_key(4'hE, 1'b0, 1'b1);
        wait_idle();

        scan_mode = 1;
        send_key(4'h9, 1'b0, 1'b0);
        repeat (40) @(posedge clk_div);
        @(negedge clk_div);
        check("stuck_still_busy", kif.busy, 1);
        scan_mode = 0;
        wait_idle();

        // key 6 sits on row 1011, column 1101
        hold_row = 4'b1011; scan_mode = 3;
        send_key(4'h6, 1'b0, 1'b0);
        repeat (4) @(negedge clk_div);
        check("pre_reset_col", keyCol, 4'b1101);
        #2 rst_n = 1'b0;
        #1 check("reset_col_immediate", keyCol, 4'hF);
        repeat (2) @(posedge clk_div);
        @(negedge clk_div); #2 rst_n = 1'b1;
        d0 = done_seen;
        repeat (30) @(posedge clk_div);
        check("no_done_after_reset", done_seen - d0, 0);

        // key C sits on row 0111; row held so every cycle outside chatter is a hit
        hold_row = 4'b0111;
        send_key(4'hC, 1'b0, 1'b0);
        n = 0;
        @(negedge clk_div);
        while (kif.busy && n < 500) begin n++; @(negedge clk_div); end
        check("busy_length", n, BNC_EFF + HOLD + GAP);
        scan_mode = 0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
